shreg_tx_ctrl: RTL and testbench

//   Sequencer for a WIDTH-bit load/shift register: parallel-to-serial transmit controller.
//   - Accepts a parallel word over a VALID/READY handshake and shifts it out serially on SO.
//   - Each bit is held for DIV clock cycles; DONE pulses when the word is complete.
//   - Sits between a parallel producer (counter, switch bank, bus) and a serial consumer (LED, pin, next stage).

---
 rtl/shreg_tx_ctrl_pkg.sv | 18 +
 rtl/shreg_cell.sv | 17 +
 rtl/shreg_nbit.sv | 50 +++++
 rtl/shreg_tx_ctrl.sv | 151 +++++++++++++++
 tb/tb_shreg_tx_ctrl.sv | 136 +++++++++++++
 5 files changed

// File: rtl/shreg_tx_ctrl_pkg.sv
// rtl/shreg_tx_ctrl_pkg.sv - FSM state encodings, serial idle level and width helper for shreg_tx_ctrl
package shreg_tx_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_PAR   = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  localparam logic SO_IDLE = 1'b0;

  // A single-cycle bit period still needs a 1-bit tick register.
  function automatic int tick_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/shreg_cell.sv
// rtl/shreg_cell.sv - single enabled flip-flop cell with async active-low clear
module shreg_cell (
  input  logic clk,
  input  logic clr_n,
  input  logic ce,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)
      q <= 1'b0;
    else if (ce)
      q <= d;
  end

endmodule

// File: rtl/shreg_nbit.sv
// rtl/shreg_nbit.sv - WIDTH-bit load/shift register built from shreg_cell; exposes head and next-head bits
module shreg_nbit #(
  parameter int WIDTH = 4,
  parameter bit LEFT  = 1'b1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             ld,
  input  logic             sh,
  input  logic [WIDTH-1:0] d,
  output logic             head,
  output logic             nxt
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] fill;
  logic             ce;

  assign ce = en & (ld | sh);

  // Bits move toward the head; zeros enter at the far end.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (LEFT) begin : g_left
      if (i == 0) begin : g_end
        assign fill[i] = 1'b0;
      end else begin : g_mid
        assign fill[i] = q[i-1];
      end
    end else begin : g_right
      if (i == WIDTH-1) begin : g_end
        assign fill[i] = 1'b0;
      end else begin : g_mid
        assign fill[i] = q[i+1];
      end
    end

    shreg_cell u_cell (
      .clk   (clk),
      .clr_n (clr_n),
      .ce    (ce),
      .d     (ld ? d[i] : fill[i]),
      .q     (q[i])
    );
  end

  assign head = LEFT ? q[WIDTH-1] : q[0];
  assign nxt  = LEFT ? q[WIDTH-2] : q[1];

endmodule

// File: rtl/shreg_tx_ctrl.sv
// rtl/shreg_tx_ctrl.sv - parallel-to-serial transmit sequencer; SHREG_PARITY_EN appends an even-parity bit
module shreg_tx_ctrl
  import shreg_tx_ctrl_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DIV       = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic             SO,
  output logic             SO_STB,
  output logic             BUSY,
  output logic             DONE
);

  localparam int TW = tick_w(DIV);
  localparam int BW = $clog2(WIDTH) + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

  state_t        state, state_n;
  logic [TW-1:0] tick, tick_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic          so_q, so_n;
  logic          armed;
  logic          ld, sh;
  logic          head, nxt;
  logic          tick_end, bit_last;
`ifdef SHREG_PARITY_EN
  logic          par_q, par_n;
`endif

  shreg_nbit #(
    .WIDTH (WIDTH),
    .LEFT  (MSB_FIRST != 0)
  ) u_sr (
    .clk   (CLK),
    .clr_n (CLR_N),
    .en    (EN),
    .ld    (ld),
    .sh    (sh),
    .d     (DIN),
    .head  (head),
    .nxt   (nxt)
  );

  assign tick_end = (tick == TICK_LAST);
  assign bit_last = (bcnt == BIT_LAST);

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state <= S_IDLE;
      tick  <= '0;
      bcnt  <= '0;
      so_q  <= SO_IDLE;
      armed <= 1'b0;
`ifdef SHREG_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      tick  <= tick_n;
      bcnt  <= bcnt_n;
      so_q  <= so_n;
      armed <= armed | EN;
`ifdef SHREG_PARITY_EN
      par_q <= par_n;
`endif
    end
  end

  // SO is computed one edge ahead so the pin itself comes straight from a flop.
  always_comb begin
    state_n = state;
    tick_n  = tick;
    bcnt_n  = bcnt;
    so_n    = so_q;
    ld      = 1'b0;
    sh      = 1'b0;
`ifdef SHREG_PARITY_EN
    par_n   = par_q;
`endif
    if (EN) begin
      case (state)
        S_IDLE: begin
          if (DIN_VALID && armed) begin
            ld      = 1'b1;
            state_n = S_SHIFT;
            tick_n  = '0;
            bcnt_n  = '0;
            so_n    = (MSB_FIRST != 0) ? DIN[WIDTH-1] : DIN[0];
`ifdef SHREG_PARITY_EN
            par_n   = ^DIN;
`endif
          end
        end
        S_SHIFT: begin
          if (tick_end) begin
            tick_n = '0;
            sh     = 1'b1;
            bcnt_n = bcnt + BW'(1);
            if (bit_last) begin
`ifdef SHREG_PARITY_EN
              state_n = S_PAR;
              so_n    = par_q;
`else
              state_n = S_FIN;
              so_n    = SO_IDLE;
`endif
            end else begin
              so_n = nxt;
            end
          end else begin
            tick_n = tick + TW'(1);
          end
        end
`ifdef SHREG_PARITY_EN
        S_PAR: begin
          if (tick_end) begin
            tick_n  = '0;
            state_n = S_FIN;
            so_n    = SO_IDLE;
          end else begin
            tick_n = tick + TW'(1);
          end
        end
`endif
        S_FIN: begin
          state_n = S_IDLE;
          so_n    = SO_IDLE;
        end
        default: begin
          state_n = S_IDLE;
          so_n    = SO_IDLE;
        end
      endcase
    end
  end

  assign DIN_READY = EN & armed & (state == S_IDLE);
  assign SO        = so_q;
  assign SO_STB    = EN & ((state == S_SHIFT) | (state == S_PAR)) & (tick == '0);
  assign BUSY      = (state != S_IDLE);
  assign DONE      = EN & (state == S_FIN);

endmodule

// File: tb/tb_shreg_tx_ctrl.sv
// tb/tb_shreg_tx_ctrl.sv - directed self-checking bench for shreg_tx_ctrl (default build or SHREG_PARITY_EN)
module tb_shreg_tx_ctrl;

  logic       CLK = 1'b0;
  logic       CLR_N;
  logic       en_a, vld_a, rdy_a, so_a, stb_a, busy_a, done_a;
  logic [3:0] din_a;
  logic       en_b, vld_b, rdy_b, so_b, stb_b, busy_b, done_b;
  logic [3:0] din_b;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected vectors are {DIN_READY, BUSY, DONE, SO_STB, SO} per cycle after capture.
  logic [4:0] t1 [7];
  logic [4:0] t2 [16];
  logic [4:0] t4 [9];
  logic       t4_en [9];
  logic [4:0] t5 [6];
  logic [4:0] t6 [14];
  int         t6_cap2;

  always #5 CLK = ~CLK;

  shreg_tx_ctrl #(.WIDTH(4), .DIV(1), .MSB_FIRST(1)) u_a (
    .CLK(CLK), .CLR_N(CLR_N), .EN(en_a), .DIN(din_a), .DIN_VALID(vld_a),
    .DIN_READY(rdy_a), .SO(so_a), .SO_STB(stb_a), .BUSY(busy_a), .DONE(done_a)
  );

  shreg_tx_ctrl #(.WIDTH(4), .DIV(3), .MSB_FIRST(0)) u_b (
    .CLK(CLK), .CLR_N(CLR_N), .EN(en_b), .DIN(din_b), .DIN_VALID(vld_b),
    .DIN_READY(rdy_b), .SO(so_b), .SO_STB(stb_b), .BUSY(busy_b), .DONE(done_b)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] obs(input bit sel);
    return sel ? {rdy_b, busy_b, done_b, stb_b, so_b}
               : {rdy_a, busy_a, done_a, stb_a, so_a};
  endfunction

  task automatic cyc(input string tag, input bit sel, input logic en, input logic [4:0] exp);
    if (sel) en_b = en; else en_a = en;
    #1;
    chk(tag, {3'b0, obs(sel)}, {3'b0, exp});
    @(posedge CLK); #1;
  endtask

  task automatic load(input string tag, input bit sel, input logic [3:0] w, input bit keep);
    if (sel) begin din_b = w; vld_b = 1'b1; en_b = 1'b1; end
    else     begin din_a = w; vld_a = 1'b1; en_a = 1'b1; end
    #1;
    chk(tag, {7'b0, (sel ? rdy_b : rdy_a)}, 8'd1);
    @(posedge CLK); #1;
    if (!keep) begin vld_a = 1'b0; vld_b = 1'b0; end
  endtask

  initial begin
`ifdef SHREG_PARITY_EN
    t1 = '{5'b01011, 5'b01010, 5'b01011, 5'b01011, 5'b01011, 5'b01100, 5'b10000};
    t2 = '{5'b01010, 5'b01000, 5'b01000, 5'b01011, 5'b01001, 5'b01001, 5'b01011, 5'b01001,
           5'b01001, 5'b01010, 5'b01000, 5'b01000, 5'b01010, 5'b01000, 5'b01000, 5'b01100};
    t4 = '{5'b01011, 5'b01000, 5'b01000, 5'b01010, 5'b01011, 5'b01011, 5'b01011, 5'b01100, 5'b10000};
    t5 = '{5'b01011, 5'b01011, 5'b01011, 5'b01011, 5'b01010, 5'b01100};
    t6 = '{5'b01011, 5'b01010, 5'b01011, 5'b01010, 5'b01010, 5'b01100, 5'b10000,
           5'b01010, 5'b01011, 5'b01010, 5'b01011, 5'b01010, 5'b01100, 5'b10000};
    t6_cap2 = 7;
`else
    t1 = '{5'b01011, 5'b01010, 5'b01011, 5'b01011, 5'b01100, 5'b10000, 5'b10000};
    t2 = '{5'b01010, 5'b01000, 5'b01000, 5'b01011, 5'b01001, 5'b01001, 5'b01011, 5'b01001,
           5'b01001, 5'b01010, 5'b01000, 5'b01000, 5'b01100, 5'b10000, 5'b10000, 5'b10000};
    t4 = '{5'b01011, 5'b01000, 5'b01000, 5'b01010, 5'b01011, 5'b01011, 5'b01100, 5'b10000, 5'b10000};
    t5 = '{5'b01011, 5'b01011, 5'b01011, 5'b01011, 5'b01100, 5'b10000};
    t6 = '{5'b01011, 5'b01010, 5'b01011, 5'b01010, 5'b01100, 5'b10000, 5'b01010,
           5'b01011, 5'b01010, 5'b01011, 5'b01100, 5'b10000, 5'b10000, 5'b10000};
    t6_cap2 = 6;
`endif
    t4_en = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    CLR_N = 1'b0;
    en_a = 1'b1; vld_a = 1'b0; din_a = 4'h0;
    en_b = 1'b1; vld_b = 1'b0; din_b = 4'h0;
    #2;
    chk("reset_a", {3'b0, obs(1'b0)}, 8'd0);
    chk("reset_b", {3'b0, obs(1'b1)}, 8'd0);
    @(posedge CLK); #1;
    chk("reset_edge_a", {3'b0, obs(1'b0)}, 8'd0);
    #2 CLR_N = 1'b1;
    #1;
    chk("rdy_before_edge", {7'b0, rdy_a}, 8'd0);
    @(posedge CLK); #1;

    // 1: 1011 MSB first, DIV=1
    load("t1_ready", 1'b0, 4'b1011, 1'b0);
    for (int i = 0; i < 7; i++) cyc($sformatf("t1_c%0d", i + 1), 1'b0, 1'b1, t1[i]);

    // 2: 0110 LSB first, DIV=3
    load("t2_ready", 1'b1, 4'b0110, 1'b0);
    for (int i = 0; i < 16; i++) cyc($sformatf("t2_c%0d", i + 1), 1'b1, 1'b1, t2[i]);

    // 4: EN low for two cycles during the second bit
    load("t4_ready", 1'b0, 4'b1011, 1'b0);
    for (int i = 0; i < 9; i++) cyc($sformatf("t4_c%0d", i + 1), 1'b0, t4_en[i], t4[i]);

    // 5: reset pulse in cycle 3 aborts the word; next word goes out intact
    load("t5_ready", 1'b0, 4'b1011, 1'b0);
    cyc("t5_c1", 1'b0, 1'b1, 5'b01011);
    cyc("t5_c2", 1'b0, 1'b1, 5'b01010);
    CLR_N = 1'b0;
    #1;
    chk("t5_abort", {3'b0, obs(1'b0)}, 8'd0);
    #1 CLR_N = 1'b1;
    @(posedge CLK); #1;
    cyc("t5_idle", 1'b0, 1'b1, 5'b10000);
    load("t5_ready2", 1'b0, 4'hF, 1'b0);
    for (int i = 0; i < 6; i++) cyc($sformatf("t5_c%0d", i + 1), 1'b0, 1'b1, t5[i]);

    // 6: DIN_VALID held across A then 5
    load("t6_ready", 1'b0, 4'hA, 1'b1);
    din_a = 4'h5;
    for (int i = 0; i < 14; i++) begin
      if (i == t6_cap2) vld_a = 1'b0;
      cyc($sformatf("t6_c%0d", i + 1), 1'b0, 1'b1, t6[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
